pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 158: payload width in bits.
REQ-002 Parameter NOP_VALUE, default all zeros (WIDTH bits): payload substituted when a bubble is inserted.
REQ-003 Parameter KEEP_MASK, default all zeros (WIDTH bits): 1-bits pass the input payload through even on bubble insertion (e.g. PC+4 field).
REQ-004 CLK  input  1  clock; all state changes on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  stage can accept a beat this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 ins_nop  input  1  replace the beat accepted this cycle with a bubble.
REQ-010 flush  input  1  discard all held beats.
REQ-011 out_valid  output  1  downstream beat present.
REQ-012 out_ready  input  1  downstream accepts this cycle.
REQ-013 out_data  output  WIDTH  downstream payload, driven directly from a register.

Function
REQ-014 Upstream transfer occurs when in_valid && in_ready; downstream transfer occurs when out_valid && out_ready.
REQ-015 Storage: main register (drives out_data) plus one skid register; states EMPTY (none held), BUSY (main only), FULL (main+skid).
REQ-016 in_ready = 1 in EMPTY/BUSY, 0 in FULL, 0 while RST high; in_ready is a function of state only, with no combinational path from out_ready.
REQ-017 out_valid = 1 in BUSY/FULL, 0 in EMPTY.
REQ-018 EMPTY: upstream transfer -> BUSY, main <= beat.
REQ-019 BUSY: upstream+downstream -> BUSY, main <= beat; upstream only -> FULL, skid <= beat; downstream only -> EMPTY; neither -> hold.
REQ-020 FULL: downstream transfer -> BUSY, main <= skid; otherwise hold both registers unchanged.
REQ-021 Stored beat = (in_data & KEEP_MASK) | (NOP_VALUE & ~KEEP_MASK) when ins_nop=1 at the transfer, else in_data.
REQ-022 ins_nop without an upstream transfer has no effect; a bubble is a valid beat and obeys the handshake.
REQ-023 Latency: beat accepted in cycle N appears on out_data/out_valid in cycle N+1 when the stage was EMPTY or BUSY with a downstream transfer.
REQ-024 Order preserved; no beat is duplicated or dropped except by flush or reset.
REQ-025 flush=1: next state EMPTY, out_valid=0 and in_ready=1 next cycle; any same-cycle upstream beat is discarded; flush overrides all handshake transitions.
REQ-026 Payload registers keep their old values on flush and on transfers that do not load them; only valid state changes.
REQ-027 Throughput: one beat per cycle sustained while out_ready=1.

Reset
REQ-028 RST=1 at a rising edge -> state EMPTY, main and skid registers = 0, out_valid=0, out_data=0.
REQ-029 RST overrides flush, ins_nop and all handshakes; held beats are lost mid-operation; in_ready=1 in the first cycle after RST deasserts.

Configuration
REQ-030 Macro PIPE_STAGE_STATS_EN defined: adds outputs stall_cnt[31:0] (cycles with out_valid && !out_ready) and nop_cnt[31:0] (bubbles accepted).
REQ-031 Both counters saturate at 32'hFFFFFFFF and clear on RST; flush does not clear them.
REQ-032 Macro undefined: the counter ports and logic do not exist; all other behaviour is identical.

Verification (WIDTH=8, NOP_VALUE=8'h00, KEEP_MASK=8'hF0)
REQ-033 Reset, then in_valid=1, in_data=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5; streaming 8'h01..8'h10 back-to-back -> identical order, 1 beat/cycle.
REQ-034 ins_nop=1 with in_data=8'hA5 accepted -> out_data=8'hA0, out_valid=1.
REQ-035 out_ready=0, send 8'h11 then 8'h22 -> FULL, in_ready=0; raise out_ready -> 8'h11 then 8'h22 out, 8'h33 offered during FULL is not accepted until in_ready=1.
REQ-036 FULL, then flush=1 together with in_valid=1 and in_data=8'h44 -> next cycle out_valid=0, in_ready=1; 8'h44 never appears at the output.
REQ-037 RST pulsed while FULL -> out_valid=0, out_data=8'h00 next cycle; with PIPE_STAGE_STATS_EN, 5 stalled cycles plus 2 bubbles -> stall_cnt=5, nop_cnt=2; RST -> both 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with one-entry skid buffer, bubble insertion and flush.
// Define PIPE_STAGE_STATS_EN to add the stall_cnt / nop_cnt statistics outputs.
module pipe_stage_reg #(
    parameter int unsigned     WIDTH     = 158,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter logic [WIDTH-1:0] KEEP_MASK = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             ins_nop,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       dbg_state
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      nop_cnt
`endif
);

    // Handshake: a beat moves on a port in any cycle where that port's valid and
    // ready are both high at the rising edge; valid never depends on ready, and
    // in_ready depends only on the held state (and RST), never on out_ready.

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] beat;
    logic             up_xfer;
    logic             dn_xfer;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;

    assign in_ready  = !RST && (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign dbg_state = state_q;

    assign up_xfer = in_valid && in_ready;
    assign dn_xfer = out_valid && out_ready;

    // Bubbles keep the masked fields (e.g. a PC+4 field) from the incoming beat.
    assign beat = ins_nop ? ((in_data & KEEP_MASK) | (NOP_VALUE & ~KEEP_MASK)) : in_data;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (up_xfer) begin
                    state_d   = BUSY;
                    load_main = 1'b1;
                end
            end
            BUSY: begin
                if (up_xfer && dn_xfer) begin
                    load_main = 1'b1;
                end else if (up_xfer) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (dn_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (dn_xfer) begin
                    state_d        = BUSY;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops everything held and any same-cycle beat; payloads stay put.
        if (flush) begin
            state_d        = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_q <= beat;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= beat;
            end
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
            nop_cnt   <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (up_xfer && ins_nop && (nop_cnt != 32'hFFFF_FFFF)) begin
                nop_cnt <= nop_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
